// File: rtl/oven_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oven_disp_pkg
// Description : Shared types, segment codes and binary-to-BCD helper for the
//               oven countdown display.
// Revision    : 1.0 - initial release
// ============================================================================
package oven_disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] mn_tens;
        logic [3:0] mn_ones;
        logic [3:0] st_tens;
        logic [3:0] st_ones;
    } bcd_time_t;

    // Segment order a..g from MSB to LSB, active-low.
    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_DASH  = 7'b1111110;

    localparam logic [5:0] max_sec = 6'd59;

    // Tens found by constant comparisons so no divider is inferred; valid for 0..99.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'd0;
        for (int k = 1; k <= 9; k++) begin
            if (value >= 7'(10 * k)) begin
                tens = 4'(k);
            end
        end
        ones = 4'(value - 7'(tens) * 7'd10);
        return {tens, ones};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_encode
// Description : BCD digit to active-low 7-segment pattern; non-decimal codes blank.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_encode
    import oven_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [0:6] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/oven_countdown_display.sv
`default_nettype none
// ============================================================================
// Module      : oven_countdown_display
// Description : Loadable MM:SS BCD countdown with IDLE/RUN/PAUSE/DONE control
//               driving six registered active-low 7-segment digits.
//               Optional blinking in PAUSE/DONE when OVEN_DISP_BLINK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module oven_countdown_display
    import oven_disp_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int MAX_MIN  = 99,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       disp_off,
    input  logic       clear,
    input  logic       load,
    input  logic [6:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [0:6] hex0,
    output logic [0:6] hex1,
    output logic [0:6] hex2,
    output logic [0:6] hex3,
    output logic [0:6] hex4,
    output logic [0:6] hex5,
    output logic       running,
    output logic       done
);

    localparam int                   c_div        = CLK_HZ / TICK_HZ;
    localparam int                   c_presc_w    = $clog2(c_div);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(c_div - 1);
    localparam logic [6:0]           c_max_min    = 7'(MAX_MIN);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_presc_w-1:0] r_presc;
    bcd_time_t            r_time;
    bcd_time_t            w_time_dec;
    bcd_time_t            w_time_load;
    logic [0:6]           r_hex      [0:5];
    logic [0:6]           w_hex_next [0:5];
    logic [3:0]           w_bcd      [0:3];
    logic [0:6]           w_seg      [0:3];

    logic       w_is_zero, w_le_one;
    logic       w_do_load, w_do_start, w_do_pause, w_count_en, w_tick;
    logic       w_blink_on;
    logic [6:0] w_min_clamped;
    logic [5:0] w_sec_clamped;
    logic [7:0] w_min_bcd, w_sec_bcd;

    assign w_is_zero = (r_time == '0);
    assign w_le_one  = (r_time.mn_tens == 4'd0) && (r_time.mn_ones == 4'd0) &&
                       (r_time.st_tens == 4'd0) && (r_time.st_ones <= 4'd1);

    // Strict priority clear > load > start > pause, even when the winner is a no-op in this state.
    assign w_do_load  = !clear && load && (r_state != S_RUN);
    assign w_do_start = !clear && !load && start &&
                        (((r_state == S_IDLE) && !w_is_zero) || (r_state == S_PAUSE));
    assign w_do_pause = !clear && !load && !start && pause && (r_state == S_RUN);
    assign w_count_en = (r_state == S_RUN) && !clear && !w_do_pause;
    assign w_tick     = w_count_en && (r_presc == c_presc_last);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_do_start) w_state_next = S_RUN;
                S_RUN: begin
                    if (w_tick && w_le_one) w_state_next = S_DONE;
                    else if (w_do_pause)    w_state_next = S_PAUSE;
                end
                S_PAUSE: if (w_do_start) w_state_next = S_RUN;
                S_DONE:  if (w_do_load)  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        running = 1'b0;
        done    = 1'b0;
        case (r_state)
            S_RUN:   running = 1'b1;
            S_DONE:  done    = 1'b1;
            default: ;
        endcase
    end

    // Prescaler holds through PAUSE so a resumed run finishes the interrupted second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (clear || w_do_load || ((r_state == S_IDLE) && w_do_start)) begin
            r_presc <= '0;
        end else if (w_count_en) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    assign w_min_clamped = (load_min > c_max_min) ? c_max_min : load_min;
    assign w_sec_clamped = (load_sec > max_sec) ? max_sec : load_sec;
    assign w_min_bcd     = bin_to_bcd(w_min_clamped);
    assign w_sec_bcd     = bin_to_bcd({1'b0, w_sec_clamped});
    assign w_time_load   = '{mn_tens: w_min_bcd[7:4], mn_ones: w_min_bcd[3:0],
                             st_tens: w_sec_bcd[7:4], st_ones: w_sec_bcd[3:0]};

    always_comb begin
        w_time_dec = r_time;
        if (r_time.st_ones != 4'd0) begin
            w_time_dec.st_ones = r_time.st_ones - 4'd1;
        end else begin
            w_time_dec.st_ones = 4'd9;
            if (r_time.st_tens != 4'd0) begin
                w_time_dec.st_tens = r_time.st_tens - 4'd1;
            end else begin
                w_time_dec.st_tens = 4'd5;
                if (r_time.mn_ones != 4'd0) begin
                    w_time_dec.mn_ones = r_time.mn_ones - 4'd1;
                end else begin
                    w_time_dec.mn_ones = 4'd9;
                    w_time_dec.mn_tens = r_time.mn_tens - 4'd1;
                end
            end
        end
    end

    // The last tick lands on 00:00 and stays there; 00:00 in RUN also ends without wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_time <= '0;
        end else if (clear) begin
            r_time <= '0;
        end else if (w_do_load) begin
            r_time <= w_time_load;
        end else if (w_tick) begin
            r_time <= w_le_one ? '0 : w_time_dec;
        end
    end

`ifdef OVEN_DISP_BLINK_EN
    localparam int                   c_blink_div  = CLK_HZ / (2 * BLINK_HZ);
    localparam int                   c_blink_w    = (c_blink_div > 1) ? $clog2(c_blink_div) : 1;
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(c_blink_div - 1);

    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blink_on = r_blink_on;
`else
    // No blink counter: phase is permanently on for any legal BLINK_HZ.
    assign w_blink_on = (BLINK_HZ > 0);
`endif

    assign w_bcd[0] = r_time.st_ones;
    assign w_bcd[1] = r_time.st_tens;
    assign w_bcd[2] = r_time.mn_ones;
    assign w_bcd[3] = r_time.mn_tens;

    for (genvar g = 0; g < 4; g++) begin : g_digit
        seg7_encode u_seg7_encode (
            .i_bcd (w_bcd[g]),
            .o_seg (w_seg[g])
        );
    end

    always_comb begin
        w_hex_next[0] = w_seg[0];
        w_hex_next[1] = w_seg[1];
        w_hex_next[2] = SEG_DASH;
        w_hex_next[3] = w_seg[2];
        w_hex_next[4] = w_seg[3];
        w_hex_next[5] = SEG_BLANK;
        if ((r_state == S_DONE) && !w_blink_on) begin
            for (int i = 0; i < 5; i++) w_hex_next[i] = SEG_BLANK;
        end
        if ((r_state == S_PAUSE) && !w_blink_on) begin
            w_hex_next[2] = SEG_BLANK;
        end
        if (disp_off) begin
            for (int i = 0; i < 6; i++) w_hex_next[i] = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) r_hex[i] <= SEG_BLANK;
        end else begin
            for (int i = 0; i < 6; i++) r_hex[i] <= w_hex_next[i];
        end
    end

    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];
    assign hex4 = r_hex[4];
    assign hex5 = r_hex[5];

endmodule
`default_nettype wire

// File: tb/tb_oven_countdown_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_oven_countdown_display
// Description : Directed and random stimulus for oven_countdown_display checked
//               against a seconds-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oven_countdown_display;

    localparam int CLK_HZ   = 10;
    localparam int TICK_HZ  = 1;
    localparam int BLINK_HZ = 1;
    localparam int MAX_MIN  = 99;
    localparam int DIV      = CLK_HZ / TICK_HZ;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       disp_off, clear, load, start, pause;
    logic [6:0] load_min;
    logic [5:0] load_sec;
    logic [0:6] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       running, done;

    int          n_total = 0;
    int          n_bad   = 0;
    int          m_state, m_secs, m_phase;
    logic [41:0] m_hex;

    always #5 clk = ~clk;

    oven_countdown_display #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .MAX_MIN  (MAX_MIN),
        .BLINK_HZ (BLINK_HZ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .disp_off (disp_off),
        .clear    (clear),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .start    (start),
        .pause    (pause),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5),
        .running  (running),
        .done     (done)
    );

    // Segments listed a..g, 0 = lit.
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] model_display(input logic off);
        int mm, ss;
        if (off) return '1;
        mm = m_secs / 60;
        ss = m_secs % 60;
        return {7'b1111111, seg_of(mm / 10), seg_of(mm % 10), 7'b1111110,
                seg_of(ss / 10), seg_of(ss % 10)};
    endfunction

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_secs  = 0;
        m_phase = 0;
        m_hex   = '1;
    endtask

    task automatic model_edge();
        logic [41:0] nh;
        int          lm, ls;
        bit          cnt;
        nh  = model_display(disp_off);
        cnt = 0;
        if (clear) begin
            m_state = M_IDLE;
            m_secs  = 0;
            m_phase = 0;
        end else if (load) begin
            if (m_state == M_RUN) begin
                cnt = 1;
            end else begin
                lm      = (int'(load_min) > MAX_MIN) ? MAX_MIN : int'(load_min);
                ls      = (int'(load_sec) > 59) ? 59 : int'(load_sec);
                m_secs  = lm * 60 + ls;
                m_phase = 0;
                if (m_state == M_DONE) m_state = M_IDLE;
            end
        end else if (start) begin
            if (m_state == M_IDLE && m_secs > 0) begin
                m_state = M_RUN;
                m_phase = 0;
            end else if (m_state == M_PAUSE) begin
                m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                cnt = 1;
            end
        end else if (pause) begin
            if (m_state == M_RUN) m_state = M_PAUSE;
        end else if (m_state == M_RUN) begin
            cnt = 1;
        end
        if (cnt) begin
            m_phase++;
            if (m_phase == DIV) begin
                m_phase = 0;
                if (m_secs <= 1) begin
                    m_secs  = 0;
                    m_state = M_DONE;
                end else begin
                    m_secs--;
                end
            end
        end
        m_hex = nh;
    endtask

    task automatic check_all();
        check_value("hex",     {hex5, hex4, hex3, hex2, hex1, hex0}, m_hex);
        check_value("running", running, m_state == M_RUN);
        check_value("done",    done,    m_state == M_DONE);
    endtask

    task automatic step(input bit c, input bit l, input bit s, input bit p, input bit d,
                        input int lm, input int ls);
        @(negedge clk);
        clear    = c;
        load     = l;
        start    = s;
        pause    = p;
        disp_off = d;
        load_min = 7'(lm);
        load_sec = 6'(ls);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        model_reset();

        // Reset holds outputs blank regardless of other inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {clear, load, start, pause, disp_off} = 5'($urandom);
            load_min = 7'($urandom);
            load_sec = 6'($urandom);
            @(posedge clk);
            #1;
            check_value("rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {42{1'b1}});
            check_value("rst_running", running, 1'b0);
            check_value("rst_done", done, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        {clear, load, start, pause, disp_off} = 5'b0;
        idle(2);

        // 01:00 borrows through every digit to 00:59.
        step(0, 1, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(11);
        check_value("borrow_hex1", hex1, seg_of(5));
        check_value("borrow_hex0", hex0, seg_of(9));
        check_value("borrow_hex3", hex3, seg_of(0));

        // 00:02 finishes 20 cycles after start and holds 00:00.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 2);
        step(0, 0, 1, 0, 0, 0, 0);
        cyc = 0;
        while (!done && cyc < 100) begin
            idle(1);
            cyc++;
        end
        check_value("done_latency", cyc, 20);
        idle(30);
        check_value("done_hold_time", {hex4, hex3, hex1, hex0},
                    {seg_of(0), seg_of(0), seg_of(0), seg_of(0)});
        step(0, 0, 1, 0, 0, 0, 0);
        check_value("done_start_ignored", done, 1'b1);
        step(0, 1, 0, 0, 0, 0, 5);
        check_value("done_load_idle", {running, done}, 2'b00);
        idle(1);
        check_value("done_load_time", hex0, seg_of(5));

        // Clamping of out-of-range load values.
        step(0, 1, 0, 0, 0, 120, 63);
        idle(1);
        check_value("clamp_9959", {hex4, hex3, hex1, hex0},
                    {seg_of(9), seg_of(9), seg_of(5), seg_of(9)});
        step(0, 1, 0, 0, 0, 0, 63);
        idle(1);
        check_value("clamp_0059", {hex4, hex3, hex1, hex0},
                    {seg_of(0), seg_of(0), seg_of(5), seg_of(9)});

        // Start at 00:00 is ignored.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        check_value("start_zero_ignored", running, 1'b0);

        // Pause at prescaler 4 for 30 cycles; resume completes the second 6 cycles later.
        step(0, 1, 0, 0, 0, 0, 10);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(4);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(30);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(6);
        check_value("resume_not_yet", hex0, seg_of(0));
        idle(1);
        check_value("resume_decrement", {hex1, hex0}, {seg_of(0), seg_of(9)});
        step(0, 1, 0, 0, 0, 42, 42);
        idle(2);
        check_value("run_load_ignored", {hex4, hex3, hex1, hex0},
                    {seg_of(0), seg_of(0), seg_of(0), seg_of(9)});

        // Same-cycle clear + load + start wins as clear.
        step(1, 1, 1, 0, 0, 7, 7);
        check_value("clear_prio_state", {running, done}, 2'b00);
        idle(1);
        check_value("clear_prio_time", {hex4, hex3, hex1, hex0},
                    {seg_of(0), seg_of(0), seg_of(0), seg_of(0)});

        // disp_off blanks while counting continues.
        step(0, 1, 0, 0, 0, 0, 5);
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 1, 0, 0);
        check_value("dispoff_blank", {hex5, hex4, hex3, hex2, hex1, hex0}, {42{1'b1}});
        check_value("dispoff_running", running, 1'b1);
        idle(1);
        check_value("dispoff_counted", hex0, seg_of(4));

        // Reset mid-RUN aborts immediately and the countdown does not resume.
        step(0, 1, 0, 0, 0, 0, 30);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(13);
        #2;
        rst = 1'b1;
        #1;
        check_value("midrun_rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {42{1'b1}});
        check_value("midrun_rst_running", running, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(25);

        // Random commands against the model.
        for (int i = 0; i < 1500; i++) begin
            int lm, ls;
            lm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 1));
            ls = int'($urandom_range(0, 63));
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 10, lm, ls);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
